led_frame_sequencer: RTL and testbench
======================================

Name: led_frame_sequencer

Overview:
- Autonomous frame player for the 32x8 LED matrix SPI driver.
- CPU preloads up to NFRAMES frames (32 x 16-bit words each) into an internal frame store.
- Block then copies each frame into the driver's register file, triggers transmission, waits for completion, holds for a programmable time, and advances.
- Sits between the CPU bus and the matrix driver; replaces per-frame CPU interrupt servicing.

Parameters:
- NFRAMES, 4, number of frames in store (power of 2, >=2).
- FW, 2, frame index width = log2(NFRAMES).
- HOLD_W, 16, width of hold-time counter.

Ports:
- in_clk  input  1  system clock (same as driver clock).
- in_rst  input  1  reset, asynchronous, active-high.
- cpu_data  input  16  frame-store write data.
- cpu_addr  input  FW+5  frame-store address {frame, word}.
- cpu_we  input  1  frame-store write enable.
- cpu_run  input  1  level: play while high.
- cfg_last  input  FW  index of last frame in sequence.
- cfg_loop  input  1  1 = wrap to frame 0 after cfg_last; 0 = stop.
- cfg_hold  input  HOLD_W  idle cycles between frames.
- drv_ready  input  1  driver READY interrupt.
- drv_data  output  16  driver write data.
- drv_addr  output  5  driver write address.
- drv_we  output  1  driver write enable.
- drv_start  output  1  driver START interrupt.
- out_busy  output  1  high in any state except IDLE.
- out_frame  output  FW  frame currently loaded/playing.
- out_done  output  1  one-cycle pulse when sequence ends.

Behaviour:
- Reset: all outputs 0; state IDLE; frame and word counters 0. Frame store contents are not reset. Reset mid-frame aborts immediately with no further drv_we or drv_start.
- Frame store: NFRAMES*32 x 16, CPU write port plus a registered sequencer read port (1-cycle latency). On same-cycle write and read of one address, the read returns the old data. CPU writes are accepted in every state.
- IDLE: if cpu_run=1, set frame=0 and go to WAIT_RDY.
- WAIT_RDY: wait for drv_ready=1, then go to LOAD.
- LOAD:
  - Word counter w runs 0..31, one per cycle, as the store read address {frame,w}.
  - drv_addr, drv_data and drv_we are registered from the store output.
  - Result: exactly 32 consecutive drv_we cycles, addr 0..31, first one 1 cycle after LOAD entry.
  - Go to START in the cycle after the last write; drv_we=0 from then on.
- START: assert drv_start and hold it until drv_ready is sampled 0, then deassert it and go to BUSY.
- BUSY: wait for drv_ready=1 (frame shifted out), then go to HOLD.
- HOLD:
  - Latch cfg_hold on entry; count down to 0.
  - cfg_hold=0 means zero extra cycles: next frame's WAIT_RDY on the following cycle.
  - Then go to NEXT.
- NEXT, evaluated in priority order:
  - cpu_run=0: pulse out_done, go to IDLE.
  - Else frame==cfg_last and cfg_loop=0: pulse out_done, go to IDLE.
  - Else frame==cfg_last and cfg_loop=1: frame=0, go to WAIT_RDY.
  - Else: frame+1, go to WAIT_RDY.
- Config sampling: cfg_last, cfg_loop and cpu_run are sampled only in NEXT/IDLE. Deasserting cpu_run mid-frame completes the current frame and its hold before stopping.
- cfg_last >= NFRAMES cannot occur because of the FW width; frame counter wraps naturally.
- drv_we is never asserted while drv_start is high or in BUSY. The driver's register file is untouched during shifting.
- out_frame = frame counter; out_busy = (state != IDLE).

Test Plan:
- Reset then cpu_run=1, drv_ready=1, frame0 words = 0x0000..0x001F -> drv_we high for 32 consecutive cycles starting 1 cycle after LOAD entry, drv_addr 0..31, drv_data = 0x0000..0x001F; then drv_start rises.
- Driver model drops ready 1 cycle after start and raises it 544 cycles later; cfg_hold=10, cfg_last=1, cfg_loop=0 -> frames 0 then 1 played, 10 idle cycles between them, single out_done pulse, out_busy falls.
- cfg_loop=1, cfg_last=3, run for 10 frames -> out_frame sequence 0,1,2,3,0,1,2,3,0,1; no out_done.
- cpu_run deasserted during BUSY of frame 2 -> frame 2 completes and holds, out_done pulses, no LOAD for frame 3.
- in_rst asserted at word 15 of LOAD -> drv_we and drv_start go 0 immediately; after release, with cpu_run=0, the block stays IDLE.
- CPU writes frame 1 word 5 in the same cycle the sequencer reads it -> old value is sent this pass, new value on the next loop.

Source files
------------

// File: rtl/led_frame_sequencer_if.sv
// Write/handshake bus between the frame sequencer (master) and the LED matrix SPI driver (slave).
interface led_frame_sequencer_if;
  logic [15:0] drv_data;
  logic [4:0]  drv_addr;
  logic        drv_we;
  logic        drv_start;
  logic        drv_ready;

  modport master (
    output drv_data,
    output drv_addr,
    output drv_we,
    output drv_start,
    input  drv_ready
  );

  modport slave (
    input  drv_data,
    input  drv_addr,
    input  drv_we,
    input  drv_start,
    output drv_ready
  );
endinterface

// File: rtl/led_frame_sequencer.sv
// Autonomous frame player: copies preloaded 32-word frames into the matrix driver,
// starts each transfer, waits for completion and a programmable hold, then advances.
module led_frame_sequencer #(
  parameter int unsigned NFRAMES = 4,
  parameter int unsigned FW      = 2,
  parameter int unsigned HOLD_W  = 16
) (
  input  logic                 in_clk,
  input  logic                 in_rst,
  input  logic [15:0]          cpu_data,
  input  logic [FW+4:0]        cpu_addr,
  input  logic                 cpu_we,
  input  logic                 cpu_run,
  input  logic [FW-1:0]        cfg_last,
  input  logic                 cfg_loop,
  input  logic [HOLD_W-1:0]    cfg_hold,
  led_frame_sequencer_if.master drv,
  output logic                 out_busy,
  output logic [FW-1:0]        out_frame,
  output logic                 out_done
);

  typedef enum logic [2:0] {
    StIdle, StWaitRdy, StLoad, StStart, StBusy, StHold, StNext
  } state_e;

  state_e              r_state;
  state_e              w_state_next;
  logic [FW-1:0]       r_frame;
  logic [5:0]          r_word;
  logic [HOLD_W-1:0]   r_hold;
  logic [15:0]         r_mem [NFRAMES*32];
  logic [15:0]         r_rd_data;
  logic [4:0]          r_drv_addr;
  logic                r_drv_we;
  logic                w_rd_en;
  logic                w_stop;

  // Word counter reaches 32 one cycle after the last read, so the final write is visible
  // before START and drv_we never overlaps drv_start.
  assign w_rd_en = (r_state == StLoad) && !r_word[5];
  assign w_stop  = !cpu_run || ((r_frame == cfg_last) && !cfg_loop);

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle:    if (cpu_run) w_state_next = StWaitRdy;
      StWaitRdy: if (drv.drv_ready) w_state_next = StLoad;
      StLoad:    if (r_word[5]) w_state_next = StStart;
      StStart:   if (!drv.drv_ready) w_state_next = StBusy;
      StBusy:    if (drv.drv_ready) w_state_next = (cfg_hold == '0) ? StNext : StHold;
      StHold:    if (r_hold <= HOLD_W'(1)) w_state_next = StNext;
      StNext:    w_state_next = w_stop ? StIdle : StWaitRdy;
      default:   w_state_next = StIdle;
    endcase
  end

  always_comb begin
    out_busy      = (r_state != StIdle);
    out_done      = (r_state == StNext) && w_stop;
    drv.drv_start = (r_state == StStart);
  end

  assign drv.drv_data = r_rd_data;
  assign drv.drv_addr = r_drv_addr;
  assign drv.drv_we   = r_drv_we;
  assign out_frame    = r_frame;

  // Store array carries no reset so it can map onto block RAM.
  always_ff @(posedge in_clk) begin
    if (cpu_we) begin
      r_mem[cpu_addr] <= cpu_data;
    end
  end

  always_ff @(posedge in_clk or posedge in_rst) begin
    if (in_rst) begin
      r_frame    <= '0;
      r_word     <= '0;
      r_hold     <= '0;
      r_rd_data  <= '0;
      r_drv_addr <= '0;
      r_drv_we   <= 1'b0;
    end else begin
      r_drv_we <= w_rd_en;
      if (w_rd_en) begin
        r_rd_data  <= r_mem[{r_frame, r_word[4:0]}];
        r_drv_addr <= r_word[4:0];
      end
      r_word <= (r_state == StLoad) ? r_word + 6'd1 : 6'd0;
      if (r_state == StBusy) begin
        r_hold <= cfg_hold;
      end else if (r_state == StHold) begin
        r_hold <= r_hold - HOLD_W'(1);
      end
      if ((r_state == StIdle) && cpu_run) begin
        r_frame <= '0;
      end else if ((r_state == StNext) && !w_stop) begin
        r_frame <= (r_frame == cfg_last) ? '0 : r_frame + FW'(1);
      end
    end
  end

endmodule

// File: tb/tb_led_frame_sequencer.sv
// Scoreboard bench for led_frame_sequencer: expected driver writes are queued per frame and
// checked as the sequencer emits them, alongside a simple SPI-driver ready/start model.
module tb_led_frame_sequencer;
  localparam int S_START = 0;
  localparam int S_READY = 1;
  localparam int S_WE    = 2;
  localparam int S_BUSY  = 3;
  localparam int S_DONE  = 4;

  typedef struct {
    logic [1:0]  frame;
    logic [4:0]  addr;
    logic [15:0] data;
  } exp_t;

  logic        clk;
  logic        rst;
  logic [15:0] cpu_data;
  logic [6:0]  cpu_addr;
  logic        cpu_we;
  logic        cpu_run;
  logic [1:0]  cfg_last;
  logic        cfg_loop;
  logic [15:0] cfg_hold;
  logic        out_busy;
  logic [1:0]  out_frame;
  logic        out_done;

  exp_t        exp_q[$];
  logic [15:0] shadow [4][32];
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_loads  = 0;
  int          n_done   = 0;
  int          n_writes = 0;
  int          run_len  = 0;
  logic        prev_done = 1'b0;

  led_frame_sequencer_if u_if ();

  led_frame_sequencer #(
    .NFRAMES(4),
    .FW     (2),
    .HOLD_W (16)
  ) u_dut (
    .in_clk   (clk),
    .in_rst   (rst),
    .cpu_data (cpu_data),
    .cpu_addr (cpu_addr),
    .cpu_we   (cpu_we),
    .cpu_run  (cpu_run),
    .cfg_last (cfg_last),
    .cfg_loop (cfg_loop),
    .cfg_hold (cfg_hold),
    .drv      (u_if),
    .out_busy (out_busy),
    .out_frame(out_frame),
    .out_done (out_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic pick(input int sel);
    case (sel)
      S_START: return u_if.drv_start;
      S_READY: return u_if.drv_ready;
      S_WE:    return u_if.drv_we;
      S_BUSY:  return out_busy;
      default: return out_done;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic val, input int budget, input string tag);
    int   n = 0;
    logic s;
    do begin
      @(negedge clk);
      s = pick(sel);
      n++;
    end while (s !== val && n < budget);
    if (s !== val) check_eq(tag, {31'd0, s}, {31'd0, val});
  endtask

  task automatic cpu_wr(input logic [6:0] a, input logic [15:0] d);
    cpu_addr = a;
    cpu_data = d;
    cpu_we   = 1'b1;
    @(posedge clk);
    #1 cpu_we = 1'b0;
  endtask

  task automatic push_frame(input int f);
    exp_t e;
    for (int w = 0; w < 32; w++) begin
      e.frame = 2'(f);
      e.addr  = 5'(w);
      e.data  = shadow[f][w];
      exp_q.push_back(e);
    end
  endtask

  // Gap from ready returning high to the next frame's first driver write.
  task automatic measure_gap(input int exp, input string tag);
    int cnt = 0;
    wait_for(S_START, 1'b1, 100, {tag, "_start"});
    wait_for(S_READY, 1'b0, 10, {tag, "_rdy_fall"});
    wait_for(S_READY, 1'b1, 700, {tag, "_rdy_rise"});
    do begin
      @(negedge clk);
      cnt++;
    end while (!u_if.drv_we && cnt < 100);
    check_eq(tag, cnt, exp);
  endtask

  task automatic run_until(input int n, input string tag);
    int t = 0;
    while (n_loads < n && t < 20000) begin
      @(negedge clk);
      t++;
    end
    check_eq({tag, "_loads"}, n_loads, n);
    wait_for(S_READY, 1'b0, 10, {tag, "_busy"});
    cpu_run = 1'b0;
  endtask

  task automatic finish_seq(input string tag);
    wait_for(S_DONE, 1'b1, 2000, {tag, "_done"});
    cpu_run = 1'b0;
    @(negedge clk);
    check_eq({tag, "_busy_fall"}, out_busy, 0);
    check_eq({tag, "_done_pulse"}, out_done, 0);
  endtask

  // Simple driver: drops ready one cycle after start, raises it 544 cycles later.
  initial begin
    u_if.drv_ready = 1'b1;
    forever begin
      @(negedge clk);
      if (u_if.drv_start === 1'b1 && u_if.drv_ready === 1'b1) begin
        @(posedge clk);
        #1 u_if.drv_ready = 1'b0;
        repeat (544) @(posedge clk);
        #1 u_if.drv_ready = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      run_len = 0;
    end else begin
      if (u_if.drv_we) begin
        n_writes++;
        run_len++;
        check_eq("we_vs_start", u_if.drv_start, 0);
        if (exp_q.size() == 0) begin
          check_eq("unexpected_write_addr", {27'd0, u_if.drv_addr}, 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check_eq("drv_addr", u_if.drv_addr, e.addr);
          check_eq("drv_data", u_if.drv_data, e.data);
          check_eq("out_frame", out_frame, e.frame);
        end
      end else if (run_len != 0) begin
        check_eq("we_run_len", run_len, 32);
        check_eq("start_after_load", u_if.drv_start, 1);
        n_loads++;
        run_len = 0;
      end
      if (out_done) begin
        n_done++;
        check_eq("done_width", prev_done, 0);
      end
      prev_done = out_done;
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    int cnt;
    int done0;
    int loads0;
    int writes0;
    rst      = 1'b1;
    cpu_data = '0;
    cpu_addr = '0;
    cpu_we   = 1'b0;
    cpu_run  = 1'b0;
    cfg_last = 2'd1;
    cfg_loop = 1'b0;
    cfg_hold = 16'd10;
    repeat (3) @(negedge clk);
    check_eq("rst_busy", out_busy, 0);
    check_eq("rst_we", u_if.drv_we, 0);
    check_eq("rst_start", u_if.drv_start, 0);
    check_eq("rst_done", out_done, 0);
    check_eq("rst_frame", out_frame, 0);
    @(posedge clk);
    #1 rst = 1'b0;

    for (int f = 0; f < 4; f++) begin
      for (int w = 0; w < 32; w++) begin
        shadow[f][w] = (f == 0) ? 16'(w) : 16'((f * 16'h1100) + w);
        cpu_wr(7'({f[1:0], w[4:0]}), shadow[f][w]);
      end
    end

    // Two frames, no loop, hold of 10.
    push_frame(0);
    push_frame(1);
    done0  = n_done;
    loads0 = n_loads;
    cpu_run = 1'b1;
    wait_for(S_BUSY, 1'b1, 10, "b_busy_rise");
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!u_if.drv_we && cnt < 10);
    check_eq("b_first_we_latency", cnt, 2);
    measure_gap(14, "b_hold_gap");
    finish_seq("b");
    check_eq("b_done_count", n_done - done0, 1);
    check_eq("b_loads", n_loads - loads0, 2);
    check_eq("b_queue_empty", exp_q.size(), 0);

    // Looping over all four frames for ten passes.
    cfg_last = 2'd3;
    cfg_loop = 1'b1;
    cfg_hold = 16'd2;
    for (int i = 0; i < 10; i++) push_frame(i % 4);
    done0  = n_done;
    loads0 = n_loads;
    @(posedge clk);
    #1 cpu_run = 1'b1;
    run_until(loads0 + 10, "c");
    check_eq("c_no_done", n_done - done0, 0);
    finish_seq("c");
    check_eq("c_done_count", n_done - done0, 1);
    check_eq("c_queue_empty", exp_q.size(), 0);

    // Stop requested while frame 2 is shifting.
    for (int i = 0; i < 3; i++) push_frame(i);
    done0  = n_done;
    loads0 = n_loads;
    @(posedge clk);
    #1 cpu_run = 1'b1;
    run_until(loads0 + 3, "d");
    check_eq("d_frame", out_frame, 2);
    finish_seq("d");
    writes0 = n_writes;
    repeat (60) @(negedge clk);
    check_eq("d_no_more_writes", n_writes - writes0, 0);
    check_eq("d_loads", n_loads - loads0, 3);
    check_eq("d_queue_empty", exp_q.size(), 0);

    // Zero hold and a CPU write colliding with the sequencer read of frame 1 word 5.
    cfg_last = 2'd1;
    cfg_hold = 16'd0;
    push_frame(0);
    push_frame(1);
    shadow[1][5] = 16'hBEEF;
    push_frame(0);
    push_frame(1);
    done0  = n_done;
    loads0 = n_loads;
    @(posedge clk);
    #1 cpu_run = 1'b1;
    measure_gap(4, "e_hold0_gap");
    cnt = 0;
    while (!(u_if.drv_we && u_if.drv_addr == 5'd4 && out_frame == 2'd1) && cnt < 100) begin
      @(negedge clk);
      cnt++;
    end
    check_eq("e_collide_sync", {31'd0, u_if.drv_we}, 1);
    cpu_wr(7'h25, 16'hBEEF);
    run_until(loads0 + 4, "e");
    finish_seq("e");
    check_eq("e_done_count", n_done - done0, 1);
    check_eq("e_queue_empty", exp_q.size(), 0);

    // Reset in the middle of a frame load.
    cfg_last = 2'd3;
    push_frame(0);
    @(posedge clk);
    #1 cpu_run = 1'b1;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(u_if.drv_we && u_if.drv_addr == 5'd15) && cnt < 100);
    check_eq("f_reach_word15", u_if.drv_addr, 15);
    rst     = 1'b1;
    cpu_run = 1'b0;
    #1;
    check_eq("f_rst_we", u_if.drv_we, 0);
    check_eq("f_rst_start", u_if.drv_start, 0);
    check_eq("f_rst_busy", out_busy, 0);
    check_eq("f_rst_frame", out_frame, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    writes0 = n_writes;
    repeat (60) @(negedge clk);
    check_eq("f_idle_busy", out_busy, 0);
    check_eq("f_idle_start", u_if.drv_start, 0);
    check_eq("f_idle_writes", n_writes - writes0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
